// File: rtl/sisc_ctrl.sv
// Multi-cycle control unit for the SISC processor: sequences each instruction
// through fixed states and decodes datapath enables from state and opcode.
module sisc_ctrl (
  input  logic       clk,
  input  logic       rst_f,
  input  logic [3:0] opcode,
  input  logic [3:0] mm,
  input  logic [3:0] stat,
  output logic       pc_rst,
  output logic       pc_write,
  output logic       pc_sel,
  output logic       br_sel,
  output logic       ir_load,
  output logic       rb_sel,
  output logic [1:0] alu_op,
  output logic       stat_en,
  output logic       mm_sel,
  output logic       dm_we,
  output logic       rf_we,
  output logic       wb_sel
);

  localparam logic [2:0] S_START0    = 3'd0;
  localparam logic [2:0] S_START1    = 3'd1;
  localparam logic [2:0] S_FETCH     = 3'd2;
  localparam logic [2:0] S_DECODE    = 3'd3;
  localparam logic [2:0] S_EXECUTE   = 3'd4;
  localparam logic [2:0] S_MEM       = 3'd5;
  localparam logic [2:0] S_WRITEBACK = 3'd6;
  localparam logic [2:0] S_HALT      = 3'd7;

  localparam logic [3:0] OP_ALU = 4'b0001;
  localparam logic [3:0] OP_BRA = 4'b0010;
  localparam logic [3:0] OP_BRR = 4'b0011;
  localparam logic [3:0] OP_BNE = 4'b0100;
  localparam logic [3:0] OP_BNR = 4'b0101;
  localparam logic [3:0] OP_LOD = 4'b1000;
  localparam logic [3:0] OP_STR = 4'b1100;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       cond_hit_c;
  logic       br_taken_c;
  logic       br_rel_c;

  // State register; reset wins from any state, including HALT.
  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q <= S_START0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state sequencing: fixed five-cycle instruction loop, HLT parks.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START0:    state_d = S_START1;
      S_START1:    state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_d = S_MEM;
      S_MEM:       state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      default:     state_d = S_HALT;
    endcase
  end

  // Branch condition: stat here is the status left by the previous ALU op.
  always_comb begin
    cond_hit_c = |(stat & mm);
    br_taken_c = 1'b0;
    br_rel_c   = 1'b0;
    case (opcode)
      OP_BRA: br_taken_c = cond_hit_c;
      OP_BRR: begin br_taken_c = cond_hit_c;  br_rel_c = 1'b1; end
      OP_BNE: br_taken_c = !cond_hit_c;
      OP_BNR: begin br_taken_c = !cond_hit_c; br_rel_c = 1'b1; end
      default: begin
        br_taken_c = 1'b0;
        br_rel_c   = 1'b0;
      end
    endcase
  end

  // Output decode of the registered state plus the held opcode.
  always_comb begin
    pc_rst   = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    ir_load  = 1'b0;
    rb_sel   = 1'b0;
    alu_op   = 2'b00;
    stat_en  = 1'b0;
    mm_sel   = 1'b0;
    dm_we    = 1'b0;
    rf_we    = 1'b0;
    wb_sel   = 1'b0;
    case (state_q)
      S_START0, S_START1: pc_rst = 1'b1;
      S_FETCH: begin
        ir_load  = 1'b1;
        pc_write = 1'b1;
      end
      S_DECODE: begin
        rb_sel = (opcode == OP_STR);
        if (br_taken_c) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
          br_sel   = br_rel_c;
        end
      end
      S_EXECUTE: begin
        rb_sel = (opcode == OP_STR);
        if (opcode == OP_ALU) begin
          alu_op  = 2'b01;
          stat_en = 1'b1;
        end else if (opcode == OP_LOD || opcode == OP_STR) begin
          alu_op = 2'b10;
        end
      end
      S_MEM: begin
        rb_sel = (opcode == OP_STR);
        mm_sel = (opcode == OP_LOD) || (opcode == OP_STR);
        dm_we  = (opcode == OP_STR);
      end
      S_WRITEBACK: begin
        rf_we  = (opcode == OP_ALU) || (opcode == OP_LOD);
        wb_sel = (opcode == OP_LOD);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/sisc_ctrl.md
# sisc_ctrl

Multi-cycle control unit for the SISC processor. It sequences every instruction through fixed fetch/decode/execute/memory/writeback states. From the current state and the 4-bit opcode held in the instruction register, it decodes all datapath enables and mux selects. One of these is `rb_sel`, which drives the select of the 4-bit register-address mux in front of the register file's second read port. It sits between the instruction register and the datapath.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_f`  in  1  synchronous active-low reset, sampled on rising edge of `clk`.
- `opcode`  in  4  instruction bits [31:28] from the IR; valid and stable from DECODE through WRITEBACK.
- `mm`  in  4  branch condition mask, IR bits [27:24].
- `stat`  in  4  status register {C,V,N,Z}.
- `pc_rst`  out  1  holds PC at 0.
- `pc_write`  out  1  PC load enable.
- `pc_sel`  out  1  0 = PC+1, 1 = branch target.
- `br_sel`  out  1  0 = absolute target, 1 = PC-relative target.
- `ir_load`  out  1  IR load enable.
- `rb_sel`  out  1  register-address mux select: 0 = rs field, 1 = rd field (store data).
- `alu_op`  out  2  00 = none, 01 = reg/reg arithmetic, 10 = address add.
- `stat_en`  out  1  status register write enable.
- `mm_sel`  out  1  memory address source: 0 = PC, 1 = ALU result.
- `dm_we`  out  1  data memory write enable.
- `rf_we`  out  1  register file write enable.
- `wb_sel`  out  1  writeback source: 0 = ALU, 1 = memory.

## Operation
- Opcodes:
  - 0000 NOP
  - 0001 ALU
  - 0010 BRA (absolute, taken if (stat & mm) != 0)
  - 0011 BRR (relative, same condition)
  - 0100 BNE (absolute, taken if (stat & mm) == 0)
  - 0101 BNR (relative, same condition)
  - 1000 LOD
  - 1100 STR
  - 1111 HLT
  - All other opcodes execute as NOP.
- States: START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- Transitions:
  - START0→START1→FETCH→DECODE.
  - DECODE→HALT if opcode = 1111; otherwise DECODE→EXECUTE.
  - EXECUTE→MEM→WRITEBACK→FETCH.
  - HALT→HALT until reset.
- Outputs are Moore/Mealy decodes of the registered state plus `opcode`/`mm`/`stat`. Every output is 0 unless listed below.
  - START0, START1: `pc_rst`=1.
  - FETCH: `ir_load`=1, `pc_write`=1, `pc_sel`=0.
  - DECODE, branch opcode taken: `pc_write`=1, `pc_sel`=1, `br_sel`=1 for 0011/0101 and 0 for 0010/0100. Not taken: PC outputs stay 0.
  - DECODE/EXECUTE/MEM with STR: `rb_sel`=1.
  - EXECUTE: `alu_op`=01 and `stat_en`=1 for 0001; `alu_op`=10 for 1000/1100.
  - MEM: LOD: `mm_sel`=1. STR: `mm_sel`=1, `dm_we`=1.
  - WRITEBACK: ALU: `rf_we`=1, `wb_sel`=0. LOD: `rf_we`=1, `wb_sel`=1.
  - HALT: all outputs 0.
- Branch condition uses `stat` as sampled in DECODE, which is the status left by the previous ALU instruction.

## Timing
- Reset:
  - Any rising edge with `rst_f`=0 forces START0, from any state including HALT and mid-instruction.
  - In START0, outputs are `pc_rst`=1 and everything else 0.
  - No in-flight write completes after a reset edge.
- After `rst_f` rises:
  - First edge: START1.
  - Second edge: FETCH.
  - Third edge: IR and PC update, state becomes DECODE.
- Every non-HLT instruction takes exactly 5 cycles, FETCH through WRITEBACK. There is no early exit for NOP or branches.
- HLT: from the DECODE of HLT, the next edge enters HALT. PC has already advanced past HLT; nothing further is written.
- `dm_we` and `rf_we` are each asserted for exactly one cycle per qualifying instruction.

## Test plan
- Reset: hold `rst_f`=0 for 3 cycles, then release. Required:
  - `pc_rst`=1 for the 3 reset cycles plus START0 and START1.
  - `ir_load`=1 exactly on the 3rd cycle after release.
- ALU, `opcode`=0001. Required:
  - EXECUTE: `alu_op`=01, `stat_en`=1.
  - WRITEBACK: `rf_we`=1, `wb_sel`=0.
  - `dm_we`=0 throughout.
- LOD then STR:
  - LOD: MEM `mm_sel`=1; WRITEBACK `rf_we`=1, `wb_sel`=1.
  - STR: `rb_sel`=1 in DECODE, EXECUTE and MEM; MEM `dm_we`=1; WRITEBACK `rf_we`=0.
- Branches:
  - BRR with `stat`=0001, `mm`=0001: DECODE `pc_write`=1, `pc_sel`=1, `br_sel`=1.
  - BRA with `mm`=0010, `stat`=0001: not taken, `pc_write`=0 in DECODE.
  - BNE with `mm`=0010, `stat`=0001: taken, `br_sel`=0.
- HLT: `opcode`=1111 reaches HALT and all outputs stay 0 for 10 cycles. A `rst_f` pulse then returns to START0.
- Mid-instruction reset: assert `rst_f`=0 in MEM of a STR. Required: `dm_we`=0 on the following cycle and state START0.
